serial_add_sequencer: RTL and testbench

//   Bit-serial add controller that sits directly upstream of the WholeAdder full-adder cell.

---
 rtl/serial_add_sequencer.sv | 113 +++++++++++
 tb/tb_serial_add_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: feeds a single external full-adder cell LSB-first,
// recirculating its carry and collecting sum bits into a result register.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and cell-drive decode; cell inputs are forced low outside SHIFT
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    fa_a       = 1'b0;
    fa_b       = 1'b0;
    fa_cin     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        fa_a   = areg[0];
        fa_b   = breg[0];
        fa_cin = carry;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand, carry, counter and result datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      areg  <= a;
      breg  <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
    end else if (state == SHIFT) begin
      // Shift form avoids a reversed part-select when WIDTH is 1
      sum   <= (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      carry <= fa_c;
      areg  <= areg >> 1;
      breg  <= breg >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        cout <= fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: WIDTH=8 and WIDTH=1 instances,
// each wired to a behavioural full-adder cell; results checked through a scoreboard.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance and its full-adder cell
  logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_s8, fa_c8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  assign fa_s8 = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_c8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_c(fa_c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  // WIDTH=1 instance and its full-adder cell
  logic       start1, cin1, fa_a1, fa_b1, fa_cin1, fa_s1, fa_c1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  assign fa_s1 = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_c1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_c(fa_c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  logic [8:0] exp_q[$];   // {cout, sum}
  int         busy_cnt = 0;

  // Monitor: every done pulse must match the oldest expected result after WIDTH busy cycles
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy8) busy_cnt++;
      if (done8) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done8), 32'(0));
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("sum", 32'(sum8), 32'(e[7:0]));
          chk("cout", 32'(cout8), 32'(e[8]));
          chk("busy_cycles", 32'(busy_cnt), 32'(8));
          chk("fa_idle", 32'({fa_a8, fa_b8, fa_cin8}), 32'(0));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_timeout"}, 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic [7:0] es, input logic ec);
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    exp_q.push_back({ec, es});
    @(negedge clk);
    start8 = 1'b0;
    wait_drain("add");
  endtask

  task automatic wait_done8(input string name);
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) chk({name, "_done_timeout"}, 32'(done8), 32'(1));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    chk("rst_sum", 32'(sum8), 32'(0));
    chk("rst_cout", 32'(cout8), 32'(0));
    chk("rst_fa", 32'({fa_a8, fa_b8, fa_cin8}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);
      chk("hold_sum", 32'(sum8), 32'(vecs[i].s));
      chk("hold_cout", 32'(cout8), 32'(vecs[i].c));
    end

    // Back-to-back: start held high, second add accepted on first IDLE edge
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    exp_q.push_back({1'b1, 8'hFF});
    wait_done8("b2b");
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    exp_q.push_back({1'b0, 8'h00});
    @(negedge clk);
    chk("b2b_idle", 32'(busy8), 32'(0));
    @(negedge clk);
    chk("b2b_rearm", 32'(busy8), 32'(1));
    start8 = 1'b0;
    wait_drain("b2b");

    // start pulse in SHIFT is ignored and operands are not re-captured
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    exp_q.push_back({1'b0, 8'h96});
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_drain("ignore");
    repeat (12) @(negedge clk);

    // Preload cout=1, then reset mid-SHIFT: no done may follow
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy8), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy8), 32'(0));
    chk("mid_rst_sum", 32'(sum8), 32'(0));
    chk("mid_rst_cout", 32'(cout8), 32'(0));
    chk("mid_rst_done", 32'(done8), 32'(0));
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // WIDTH=1: one SHIFT edge, done on the following cycle
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", 32'(busy1), 32'(1));
    chk("w1_fa", 32'({fa_a1, fa_b1, fa_cin1}), 32'(3'b111));
    @(negedge clk);
    chk("w1_done", 32'(done1), 32'(1));
    chk("w1_sum", 32'(sum1), 32'(1));
    chk("w1_cout", 32'(cout1), 32'(1));
    @(negedge clk);
    chk("w1_done_clear", 32'(done1), 32'(0));

    // Random vectors against a+b+cin
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] full;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      full = 9'(ra) + 9'(rb) + 9'(rc);
      run_add(ra, rb, rc, full[7:0], full[8]);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
